temp_bcd_ctrl: RTL and testbench

TEMP_BCD_CTRL -- requirements
Module: temp_bcd_ctrl

---
 rtl/temp_bcd_ctrl.sv | 141 ++++++++++++++
 tb/tb_temp_bcd_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/temp_bcd_ctrl.sv
// Binary temperature to three-digit BCD converter (serial double-dabble) whose display updates only on frame_start.
// Optional build macro TEMP_BLANK_LEAD_ZERO_EN blanks leading zero digits with glyph code 4'hF.
module temp_bcd_ctrl #(
   parameter int TEMP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [TEMP_W-1:0] temp_in,
   input  logic              temp_valid,
   output logic              temp_ready,
   input  logic              frame_start,
   output logic [3:0]        temp_value_100,
   output logic [3:0]        temp_value_10,
   output logic [3:0]        temp_value_1,
   output logic              digits_valid,
   output logic              busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [3:0] LAST_ITER = 4'(TEMP_W - 1);

   logic [1:0]        state_q, state_d;
   logic [TEMP_W-1:0] sh_q, sh_d;
   logic [11:0]       bcd_q, bcd_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        d100_q, d100_d, d10_q, d10_d, d1_q, d1_d;
   logic              dv_q, dv_d;
   logic              ready_q, busy_q;
   logic [3:0]        hund_code_s, tens_code_s;

   // One double-dabble iteration: correct every nibble, then shift in the next sample bit.
   function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic in_bit);
      logic [11:0] adj;
      adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end else begin
            adj[i*4 +: 4] = bcd[i*4 +: 4];
         end
      end
      return {adj[10:0], in_bit};
   endfunction

   // Display codes for the upper two places.
   always_comb begin
`ifdef TEMP_BLANK_LEAD_ZERO_EN
      hund_code_s = (bcd_q[11:8] == 4'd0) ? 4'hF : bcd_q[11:8];
      tens_code_s = ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)) ? 4'hF : bcd_q[7:4];
`else
      hund_code_s = bcd_q[11:8];
      tens_code_s = bcd_q[7:4];
`endif
   end

   // Next-state and datapath logic.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      d100_d  = d100_q;
      d10_d   = d10_q;
      d1_d    = d1_q;
      dv_d    = dv_q;
      case (state_q)
         IDLE: begin
            if (temp_valid) begin
               sh_d    = temp_in;
               bcd_d   = 12'd0;
               cnt_d   = 4'd0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            bcd_d = dabble_step(bcd_q, sh_q[TEMP_W-1]);
            sh_d  = {sh_q[TEMP_W-2:0], 1'b0};
            if (cnt_q == LAST_ITER) begin
               cnt_d   = 4'd0;
               state_d = HOLD;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         HOLD: begin
            // Display changes only here, so it can never tear mid-frame.
            if (frame_start) begin
               d100_d  = hund_code_s;
               d10_d   = tens_code_s;
               d1_d    = bcd_q[3:0];
               dv_d    = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bcd_q   <= 12'd0;
         cnt_q   <= 4'd0;
         d100_q  <= 4'd0;
         d10_q   <= 4'd0;
         d1_q    <= 4'd0;
         dv_q    <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         d100_q  <= d100_d;
         d10_q   <= d10_d;
         d1_q    <= d1_d;
         dv_q    <= dv_d;
         ready_q <= (state_d == IDLE);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign temp_ready     = ready_q;
   assign busy           = busy_q;
   assign temp_value_100 = d100_q;
   assign temp_value_10  = d10_q;
   assign temp_value_1   = d1_q;
   assign digits_valid   = dv_q;

endmodule

// File: tb/tb_temp_bcd_ctrl.sv
// Randomized self-checking bench for temp_bcd_ctrl against a transaction-timeline reference model.
module tb_temp_bcd_ctrl;

   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [TW-1:0] temp_in = '0;
   logic          temp_valid = 1'b0;
   logic          frame_start = 1'b0;
   logic          temp_ready, digits_valid, busy;
   logic [3:0]    v100, v10, v1;

   logic [8:0]    tin9 = 9'd0;
   logic          valid9 = 1'b0;
   logic          fs9 = 1'b0;
   logic          ready9, dv9, busy9;
   logic [3:0]    w100, w10, w1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: display is updated on the first frame_start at least TW+1 edges after accept.
   int   edge_n = 0;
   int   acc_edge = 0;
   bit   pending = 0;
   int   pend_val = 0;
   logic [11:0] exp_disp = 12'd0;
   bit   exp_dv = 0;

   temp_bcd_ctrl #(.TEMP_W(TW)) u_dut (
      .clk(clk), .rst_n(rst_n), .temp_in(temp_in), .temp_valid(temp_valid),
      .temp_ready(temp_ready), .frame_start(frame_start),
      .temp_value_100(v100), .temp_value_10(v10), .temp_value_1(v1),
      .digits_valid(digits_valid), .busy(busy)
   );

   temp_bcd_ctrl #(.TEMP_W(9)) u_dut9 (
      .clk(clk), .rst_n(rst_n), .temp_in(tin9), .temp_valid(valid9),
      .temp_ready(ready9), .frame_start(fs9),
      .temp_value_100(w100), .temp_value_10(w10), .temp_value_1(w1),
      .digits_valid(dv9), .busy(busy9)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] conv(input int v);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
`ifdef TEMP_BLANK_LEAD_ZERO_EN
      if (h == 0 && t == 0) t = 15;
      if (h == 0) h = 15;
`endif
      return {h[3:0], t[3:0], o[3:0]};
   endfunction

   task automatic step(input logic v, input int t, input logic fs, input logic r);
      temp_valid  = v;
      temp_in     = t[TW-1:0];
      frame_start = fs;
      rst_n       = r;
      @(posedge clk);
      edge_n++;
      if (!r) begin
         pending  = 0;
         exp_disp = 12'd0;
         exp_dv   = 0;
      end else if (pending) begin
         if (fs && (edge_n >= acc_edge + TW + 1)) begin
            exp_disp = conv(pend_val);
            exp_dv   = 1;
            pending  = 0;
         end
      end else if (v) begin
         pending  = 1;
         pend_val = t % 256;
         acc_edge = edge_n;
      end
      @(negedge clk);
      check_val("temp_ready", temp_ready, !pending);
      check_val("busy", busy, pending);
      check_val("digits_valid", digits_valid, exp_dv);
      check_val("digits", {v100, v10, v1}, exp_disp);
   endtask

   initial begin
      int low_cnt;
      int vals9[5];
      logic [11:0] e9;

      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check_val("reset_digits", {v100, v10, v1}, 12'd0);

      // 72 with frame_start held high: ready must be low for exactly TW+1 cycles
      low_cnt = 0;
      step(1, 72, 1, 1);
      if (!temp_ready) low_cnt++;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 1, 1);
         if (!temp_ready) low_cnt++;
      end
      check_val("ready_low_cycles", low_cnt, TW + 1);
      check_val("disp_72", {v100, v10, v1}, conv(72));

      // 255, then 5 and 40 (leading-zero cases)
      step(1, 255, 0, 1);
      for (int i = 0; i < TW + 3; i++) step(0, 0, i == TW + 2, 1);
      step(1, 5, 0, 1);
      for (int i = 0; i < TW + 1; i++) step(0, 0, 0, 1);
      step(0, 0, 1, 1);
      step(1, 40, 0, 1);
      for (int i = 0; i < TW + 1; i++) step(0, 0, 0, 1);
      step(0, 0, 1, 1);
      check_val("disp_40", {v100, v10, v1}, conv(40));

      // frame_start pulses during SHIFT must not update the display
      step(1, 123, 0, 1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      step(0, 0, 1, 1);
      check_val("no_update_in_shift", {v100, v10, v1}, conv(40));
      for (int i = 0; i < TW; i++) step(0, 0, 0, 1);
      step(0, 0, 1, 1);
      check_val("disp_123", {v100, v10, v1}, conv(123));

      // valid held high through HOLD: only the value present after IDLE is taken
      step(1, 200, 0, 1);
      for (int i = 0; i < TW + 2; i++) step(1, 99, 0, 1);
      step(1, 10, 1, 1);
      step(1, 10, 0, 1);
      for (int i = 0; i < TW + 1; i++) step(0, 0, 0, 1);
      step(0, 0, 1, 1);
      check_val("disp_10", {v100, v10, v1}, conv(10));

      // show 72, then reset in mid-SHIFT
      step(1, 72, 0, 1);
      for (int i = 0; i < TW + 1; i++) step(0, 0, 0, 1);
      step(0, 0, 1, 1);
      step(1, 150, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 1, 0);
      check_val("rst_digits", {v100, v10, v1}, 12'd0);
      check_val("rst_ready", temp_ready, 1'b1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 199) != 0));
      end

      // 9-bit instance: full range including 511
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      vals9[0] = 511; vals9[1] = 500; vals9[2] = 0; vals9[3] = 256;
      vals9[4] = int'($urandom_range(0, 511));
      for (int k = 0; k < 5; k++) begin
         tin9   = vals9[k][8:0];
         valid9 = 1'b1;
         step(0, 0, 0, 1);
         valid9 = 1'b0;
         for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
         check_val("w9_no_update_before_fs", dv9, k != 0);
         fs9 = 1'b1;
         step(0, 0, 0, 1);
         fs9 = 1'b0;
         e9 = conv(vals9[k]);
         check_val("w9_digits", {w100, w10, w1}, e9);
         check_val("w9_dv", dv9, 1'b1);
         check_val("w9_ready", ready9, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
